// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a big-endian byte stream into 32-bit words
// and writes them to a 64x32 instruction memory while stalling the fetch stage.
module instr_mem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        load_abort,
    input  logic [6:0]  word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [5:0]  cpu_addr,
    output logic [5:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    output logic        cpu_stall,
    output logic        busy,
    output logic        load_done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ASSEMBLE = 2'd1,
        S_WRITE    = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_wptr;
    logic [1:0]  r_bcnt;
    logic [6:0]  r_count;
    logic [31:0] r_word;
    logic        r_err;

    logic w_start_req;
    logic w_count_ok;
    logic w_accept;
    logic w_last_word;

    // Abort outranks start, so a simultaneous abort suppresses both start and err.
    assign w_start_req = load_start && !load_abort;
    assign w_count_ok  = (word_count != 7'd0) && (word_count <= 7'd64);
    assign w_accept    = (r_state == S_ASSEMBLE) && byte_valid;
    assign w_last_word = (({1'b0, r_wptr} + 7'd1) == r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_req && w_count_ok) begin
                    w_next = S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: begin
                if (load_abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && (r_bcnt == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (load_abort) begin
                    w_next = S_IDLE;
                end else if (w_last_word) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ASSEMBLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= 6'd0;
            r_bcnt  <= 2'd0;
            r_count <= 7'd0;
            r_word  <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= (r_state == S_IDLE) && w_start_req && !w_count_ok;
            case (r_state)
                S_IDLE: begin
                    if (w_start_req && w_count_ok) begin
                        r_count <= word_count;
                        r_wptr  <= 6'd0;
                        r_bcnt  <= 2'd0;
                    end
                end
                S_ASSEMBLE: begin
                    if (w_accept) begin
                        r_word <= {r_word[23:0], byte_data};
                        r_bcnt <= r_bcnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    r_bcnt <= 2'd0;
                    // Pointer holds at 63 after the 64th word rather than wrapping.
                    if (r_wptr != 6'd63) begin
                        r_wptr <= r_wptr + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b1;
        load_done  = 1'b0;
        mem_addr   = r_wptr;
        case (r_state)
            S_IDLE: begin
                busy     = 1'b0;
                mem_addr = cpu_addr;
            end
            S_ASSEMBLE: byte_ready = 1'b1;
            S_WRITE:    mem_we     = 1'b1;
            S_DONE:     load_done  = 1'b1;
            default: begin
            end
        endcase
        cpu_stall = busy;
        mem_wdata = r_word;
        err       = r_err;
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: expected writes are queued as bytes
// are driven and matched against mem_we strobes observed on the falling edge.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_abort = 1'b0;
    logic [6:0]  word_count = 7'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic [5:0]  cpu_addr = 6'd0;
    logic        byte_ready;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        cpu_stall;
    logic        busy;
    logic        load_done;
    logic        err;

    instr_mem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cpu_addr   (cpu_addr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .cpu_stall  (cpu_stall),
        .busy       (busy),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          when;
    } wr_t;

    wr_t         sb[$];
    wr_t         e_m;
    logic [31:0] wq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int exp_done = -1;
    bit done_ok = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the cycle right after the edge that samples load_start.
    function automatic int rel();
        return cyc - start_cyc + 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_we", 64'd1, 64'd0);
                end else begin
                    e_m = sb.pop_front();
                    check("wr_addr", {58'd0, mem_addr}, {58'd0, e_m.addr});
                    check("wr_data", {32'd0, mem_wdata}, {32'd0, e_m.data});
                    check("ready_in_write", {63'd0, byte_ready}, 64'd0);
                    if (e_m.when >= 0) check("wr_cycle", rel(), e_m.when);
                end
            end
            if (load_done) begin
                done_cnt++;
                if (!done_ok) check("unexpected_done", 64'd1, 64'd0);
                else if (exp_done >= 0) check("done_cycle", rel(), exp_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int n);
        word_count = n[6:0];
        load_start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        load_start = 1'b0;
        check("stall_c1", {63'd0, cpu_stall}, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int nbytes, input bit thr);
        int guard;
        for (int i = 0; i < nbytes; i++) begin
            byte_data  = w[31-8*i -: 8];
            byte_valid = 1'b1;
            guard = 0;
            while (!byte_ready && guard < 10) begin
                tick();
                guard++;
            end
            if (!byte_ready) begin
                check("ready_timeout", 64'd0, 64'd1);
                return;
            end
            tick();
            if (thr) begin
                byte_valid = 1'b0;
                byte_data  = 8'hEE;
                tick();
            end
        end
    endtask

    task automatic wait_idle(output int c);
        int guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        check("idle_timeout", {63'd0, busy}, 64'd0);
        c = rel();
    endtask

    task automatic run_load(input int n, input bit thr);
        int d0;
        int c;
        d0 = done_cnt;
        done_ok  = 1'b1;
        exp_done = thr ? -1 : 5 * n + 1;
        start_load(n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{addr: i[5:0], data: wq[i], when: (thr ? -1 : 5 * (i + 1))});
            send_word(wq[i], 4, thr);
        end
        byte_valid = 1'b0;
        wait_idle(c);
        if (!thr) check("idle_cycle", c, 5 * n + 2);
        check("stall_idle", {63'd0, cpu_stall}, 64'd0);
        check("done_count", done_cnt - d0, 1);
        check("sb_empty", sb.size(), 0);
        done_ok  = 1'b0;
        exp_done = -1;
    endtask

    task automatic illegal_start(input logic [6:0] n);
        int w0;
        w0 = we_cnt;
        word_count = n;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("err_pulse", {63'd0, err}, 64'd1);
        check("err_busy", {63'd0, busy}, 64'd0);
        tick();
        check("err_clear", {63'd0, err}, 64'd0);
        check("err_busy2", {63'd0, busy}, 64'd0);
        check("err_no_we", we_cnt - w0, 0);
    endtask

    initial begin
        int w0;
        int d0;
        cpu_addr = 6'h05;
        #3;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_we", {63'd0, mem_we}, 64'd0);
        check("rst_ready", {63'd0, byte_ready}, 64'd0);
        check("rst_stall", {63'd0, cpu_stall}, 64'd0);
        check("rst_done", {63'd0, load_done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_addr", {58'd0, mem_addr}, 64'h05);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        check("idle_addr5", {58'd0, mem_addr}, 64'h05);
        cpu_addr = 6'h2A;
        #1;
        check("idle_addr2a", {58'd0, mem_addr}, 64'h2A);
        check("idle_we", {63'd0, mem_we}, 64'd0);
        tick();

        wq = '{32'h8C010004};
        run_load(1, 1'b0);

        illegal_start(7'd0);
        illegal_start(7'd65);

        wq = '{32'hDEADBEEF, 32'h01234567};
        run_load(2, 1'b1);

        wq.delete();
        for (int i = 0; i < 64; i++) wq.push_back($urandom);
        run_load(64, 1'b0);

        // Abort after two bytes of the second word of a three-word load.
        w0 = we_cnt;
        d0 = done_cnt;
        start_load(3);
        sb.push_back('{addr: 6'd0, data: 32'hA1B2C3D4, when: 5});
        send_word(32'hA1B2C3D4, 4, 1'b0);
        send_word(32'h55667788, 2, 1'b0);
        load_abort = 1'b1;
        byte_valid = 1'b0;
        tick();
        load_abort = 1'b0;
        check("abort_idle", {63'd0, busy}, 64'd0);
        check("abort_ready", {63'd0, byte_ready}, 64'd0);
        repeat (3) tick();
        check("abort_writes", we_cnt - w0, 1);
        check("abort_no_done", done_cnt - d0, 0);

        // Abort sampled in WRITE still performs that write.
        w0 = we_cnt;
        start_load(2);
        sb.push_back('{addr: 6'd0, data: 32'h0BADF00D, when: 5});
        send_word(32'h0BADF00D, 4, 1'b0);
        byte_valid = 1'b0;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        check("abort_wr_idle", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        check("abort_wr_count", we_cnt - w0, 1);
        check("abort_wr_done", done_cnt - d0, 0);

        // Reset in the middle of the second word.
        w0 = we_cnt;
        cpu_addr = 6'h11;
        start_load(3);
        sb.push_back('{addr: 6'd0, data: 32'hCAFEBABE, when: 5});
        send_word(32'hCAFEBABE, 4, 1'b0);
        send_word(32'h13579BDF, 2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", {63'd0, busy}, 64'd0);
        check("mrst_stall", {63'd0, cpu_stall}, 64'd0);
        check("mrst_ready", {63'd0, byte_ready}, 64'd0);
        check("mrst_we", {63'd0, mem_we}, 64'd0);
        check("mrst_done", {63'd0, load_done}, 64'd0);
        check("mrst_err", {63'd0, err}, 64'd0);
        check("mrst_addr", {58'd0, mem_addr}, 64'h11);
        check("mrst_wdata", {32'd0, mem_wdata}, 64'd0);
        byte_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("mrst_writes", we_cnt - w0, 1);
        check("mrst_no_done", done_cnt - d0, 0);
        wq = '{32'h24680ACE};
        run_load(1, 1'b0);

        // Abort and start together in IDLE.
        load_abort = 1'b1;
        load_start = 1'b1;
        word_count = 7'd1;
        tick();
        check("prio_busy", {63'd0, busy}, 64'd0);
        check("prio_err", {63'd0, err}, 64'd0);
        word_count = 7'd0;
        tick();
        load_abort = 1'b0;
        load_start = 1'b0;
        check("prio_busy0", {63'd0, busy}, 64'd0);
        check("prio_err0", {63'd0, err}, 64'd0);
        tick();
        check("prio_err1", {63'd0, err}, 64'd0);

        check("final_sb", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
